btn_press_emulator: RTL and testbench

Synthesizable mechanical-switch emulator. It generates a bouncy, active-high button waveform on command: a randomized bounce burst on press, a clean hold of programmable length, and a randomized bounce burst on release. It drives the button input of the board-level button debouncer on-chip, for self-test and for hardware-in-loop regression of the button path without physical presses.

---
 rtl/btn_press_emulator.sv | 158 +++++++++++++++
 tb/tb_btn_press_emulator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_press_emulator.sv
// Bouncy mechanical-button waveform generator: press bounce burst, clean hold, release bounce burst.
// All transitions land on posedges; gaps come from a 16-bit LFSR that only advances on gap loads.
module btn_press_emulator #(
  parameter int          BOUNCE_EDGES = 4,
  parameter int          BOUNCE_MIN   = 50000,
  parameter int          RAND_W       = 12,
  parameter int          HOLD_W       = 32,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic              ready,
  output logic              done,
  output logic              btn,
  output logic [15:0]       presses
);

  localparam int          CW       = (HOLD_W > 16) ? HOLD_W : 16;
  localparam logic [15:0] SEED_EFF = (SEED == 16'd0) ? 16'hACE1 : SEED;
  localparam logic [15:0] RMASK    = 16'((32'd1 << RAND_W) - 32'd1);
  localparam logic [15:0] EDGES    = 16'(BOUNCE_EDGES);
  localparam logic [15:0] BMIN     = 16'(BOUNCE_MIN);

  typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HOLD, S_RELEASE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [15:0]       edges_q, edges_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       presses_q, presses_d;
  logic              btn_q, btn_d;
  logic              done_q, done_d;
  logic              load_gap;
  logic              expire;
  logic [15:0]       gap;

  // A masked add keeps RAND_W=0 legal (no zero-width part select).
  assign gap    = BMIN + (lfsr_q & RMASK);
  assign expire = (cnt_q == CW'(1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    edges_d   = edges_q;
    lfsr_d    = lfsr_q;
    presses_d = presses_q;
    btn_d     = btn_q;
    done_d    = 1'b0;
    load_gap  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_PRESS;
          hold_d   = (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
          edges_d  = EDGES;
          load_gap = 1'b1;
        end
      end
      S_PRESS: begin
        if (expire) begin
          btn_d = ~btn_q;
          if (edges_q == 16'd0) begin
            state_d = S_HOLD;
            cnt_d   = CW'(hold_q);
          end else begin
            edges_d  = edges_q - 16'd1;
            load_gap = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (expire) begin
          btn_d = 1'b0;
          if (EDGES == 16'd0) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            done_d    = 1'b1;
            presses_d = presses_q + 16'd1;
          end else begin
            state_d  = S_RELEASE;
            edges_d  = EDGES;
            load_gap = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        if (expire) begin
          btn_d   = ~btn_q;
          edges_d = edges_q - 16'd1;
          if (edges_q == 16'd1) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            done_d    = 1'b1;
            presses_d = presses_q + 16'd1;
          end else begin
            load_gap = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase

    if (load_gap) begin
      cnt_d  = CW'(gap);
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    // Abort wins over any transition due on the same edge.
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      btn_d     = 1'b0;
      cnt_d     = '0;
      edges_d   = 16'd0;
      lfsr_d    = lfsr_q;
      presses_d = presses_q;
      done_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      edges_q   <= 16'd0;
      lfsr_q    <= SEED_EFF;
      presses_q <= 16'd0;
      btn_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      edges_q   <= edges_d;
      lfsr_q    <= lfsr_d;
      presses_q <= presses_d;
      btn_q     <= btn_d;
      done_q    <= done_d;
    end
  end

  assign ready   = (state_q == S_IDLE);
  assign done    = done_q;
  assign btn     = btn_q;
  assign presses = presses_q;

endmodule

// File: tb/tb_btn_press_emulator.sv
// Randomized press/abort/start stimulus; a press-level model schedules expected btn edges and done
// pulses into queues that a negedge monitor pops and compares.
module tb_btn_press_emulator;

  localparam int          BE     = 2;
  localparam int          BMIN   = 4;
  localparam int          RW     = 4;
  localparam int          HW     = 16;
  localparam logic [15:0] SEEDV  = 16'hACE1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [HW-1:0] hold_cycles = '0;
  logic          ready, done, btn;
  logic [15:0]   presses;

  btn_press_emulator #(
    .BOUNCE_EDGES(BE), .BOUNCE_MIN(BMIN), .RAND_W(RW), .HOLD_W(HW), .SEED(SEEDV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .hold_cycles(hold_cycles),
    .ready(ready), .done(done), .btn(btn), .presses(presses)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic lvl; } ev_t;
  typedef struct { int cyc; logic [15:0] cnt; } dn_t;

  ev_t         evq[$];
  dn_t         dnq[$];
  int          load_cyc[$];
  logic [15:0] load_after[$];
  int          cyc = 0;
  int          vectors = 0;
  int          errors = 0;
  logic [15:0] m_lfsr = SEEDV;
  int          m_completed = 0;
  int          busy_from = 0;
  int          busy_to = 0;
  int          cur_ep = 0;
  bit          mon_en = 1'b0;
  logic        prev_btn = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] adv(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic bit m_busy(input int c);
    return (c >= busy_from) && (c < busy_to);
  endfunction

  // Builds the whole waveform of one press from its accept edge onward.
  task automatic issue_press(input int e0, input int h);
    int t;
    int g;
    logic lvl;
    t = e0;
    lvl = 1'b0;
    load_cyc.delete();
    load_after.delete();
    for (int i = 0; i <= BE; i++) begin
      g = BMIN + int'(m_lfsr % 16);
      m_lfsr = adv(m_lfsr);
      load_cyc.push_back(t);
      load_after.push_back(m_lfsr);
      t = t + g;
      lvl = ~lvl;
      evq.push_back('{t, lvl});
    end
    cur_ep = t;
    t = t + ((h == 0) ? 1 : h);
    lvl = 1'b0;
    evq.push_back('{t, lvl});
    for (int i = 1; i <= BE; i++) begin
      g = BMIN + int'(m_lfsr % 16);
      m_lfsr = adv(m_lfsr);
      load_cyc.push_back(t);
      load_after.push_back(m_lfsr);
      t = t + g;
      lvl = ~lvl;
      evq.push_back('{t, lvl});
    end
    m_completed++;
    dnq.push_back('{t, 16'(m_completed)});
    busy_from = e0;
    busy_to = t;
  endtask

  task automatic do_abort(input int a);
    ev_t e;
    logic prev_lvl;
    prev_lvl = 1'b0;
    while (evq.size() > 0 && evq[evq.size()-1].cyc >= a) begin
      e = evq.pop_back();
      prev_lvl = ~e.lvl;
    end
    if (prev_lvl) evq.push_back('{a, 1'b0});
    while (dnq.size() > 0 && dnq[dnq.size()-1].cyc >= a) begin
      void'(dnq.pop_back());
      m_completed--;
    end
    busy_to = a;
    for (int k = 0; k < load_cyc.size(); k++)
      if (load_cyc[k] < a) m_lfsr = load_after[k];
  endtask

  always @(negedge clk) begin
    ev_t e;
    dn_t d;
    if (mon_en && rst_n) begin
      vectors++;
      if (ready !== !m_busy(cyc)) begin
        errors++;
        $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, !m_busy(cyc));
      end
      if (btn !== prev_btn) begin
        vectors++;
        if (evq.size() == 0) begin
          errors++;
          $display("FAIL btn_edge cyc=%0d got=%b exp=no change", cyc, btn);
        end else begin
          e = evq.pop_front();
          if (e.cyc != cyc || e.lvl !== btn) begin
            errors++;
            $display("FAIL btn_edge got cyc=%0d lvl=%b exp cyc=%0d lvl=%b", cyc, btn, e.cyc, e.lvl);
          end
        end
      end else if (evq.size() > 0 && evq[0].cyc <= cyc) begin
        vectors++;
        errors++;
        e = evq.pop_front();
        $display("FAIL btn_missing cyc=%0d got=%b exp cyc=%0d lvl=%b", cyc, btn, e.cyc, e.lvl);
      end
      if (done) begin
        vectors++;
        if (dnq.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d got=1 exp=0", cyc);
        end else begin
          d = dnq.pop_front();
          if (d.cyc != cyc || presses !== d.cnt) begin
            errors++;
            $display("FAIL done got cyc=%0d presses=%0d exp cyc=%0d presses=%0d", cyc, presses, d.cyc, d.cnt);
          end
        end
      end else if (dnq.size() > 0 && dnq[0].cyc <= cyc) begin
        vectors++;
        errors++;
        d = dnq.pop_front();
        $display("FAIL done_missing cyc=%0d got=0 exp cyc=%0d", cyc, d.cyc);
      end
    end
    prev_btn = btn;
  end

  task automatic check_idle_outputs(input string tag);
    vectors++;
    if (btn !== 1'b0 || ready !== 1'b1 || done !== 1'b0 || presses !== 16'd0) begin
      errors++;
      $display("FAIL %s got btn=%b ready=%b done=%b presses=%0d exp 0 1 0 0", tag, btn, ready, done, presses);
    end
  endtask

  task automatic model_reset();
    evq.delete();
    dnq.delete();
    load_cyc.delete();
    load_after.delete();
    m_lfsr = SEEDV;
    m_completed = 0;
    busy_from = 0;
    busy_to = 0;
  endtask

  task automatic run_random(input int n);
    int r;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      hold_cycles = HW'($urandom_range(0, 12));
      r = $urandom_range(0, 99);
      if (!m_busy(cyc)) begin
        if (r < 20) begin
          start = 1'b1;
          if (r < 4) abort = 1'b1;
          issue_press(cyc + 1, int'(hold_cycles));
        end else if (r < 25) begin
          abort = 1'b1;
        end
      end else begin
        if (r < 2) begin
          abort = 1'b1;
          do_abort(cyc + 1);
        end else if (r < 8) begin
          start = 1'b1;
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 1000 && (m_busy(cyc) || evq.size() > 0 || dnq.size() > 0); k++)
      @(negedge clk);
    @(negedge clk);
    vectors++;
    if (m_busy(cyc) || evq.size() > 0 || dnq.size() > 0) begin
      errors++;
      $display("FAIL %s pending edges=%0d dones=%0d exp 0 0", tag, evq.size(), dnq.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    mon_en = 1'b1;

    run_random(4000);
    drain("drain1");

    // Reset in the middle of a hold must clear everything immediately.
    @(negedge clk);
    start = 1'b1;
    hold_cycles = HW'(10);
    issue_press(cyc + 1, 10);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 300 && cyc < cur_ep + 3; k++) @(negedge clk);
    vectors++;
    if (cyc < cur_ep + 3) begin
      errors++;
      $display("FAIL hold_wait cyc=%0d exp>=%0d", cyc, cur_ep + 3);
    end
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset_mid_hold");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_btn = 1'b0;
    mon_en = 1'b1;

    run_random(2000);
    drain("drain2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
